route_table_ctrl: RTL and testbench

- Owns a router's internal routing table and shares its single lookup port between the per-channel RX units and one configuration writer.
- After reset it preloads the table from an external source, one entry per cycle.
- It then serves RX destination lookups using round-robin arbitration with a 4-phase req/ack handshake, plus runtime table writes.
- It sits between the RX units and the switch arbiters; it replaces the ad-hoc table preload and combinational table reads inside the router.

---
 rtl/route_table_ctrl.sv | 132 +++++++++++++
 tb/tb_route_table_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/route_table_ctrl.sv
// Routing table owner: preloads from an external source after reset, then serves
// round-robin RX lookups and config writes over 4-phase req/ack handshakes.

module route_table_lane #(
  parameter int CHANNEL_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    grant,
  input  logic [CHANNEL_BITS-1:0] rd_data,
  output logic                    ack,
  output logic [CHANNEL_BITS-1:0] data
);
  // ack clears whenever req is sampled low, regardless of arbitration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack  <= 1'b0;
      data <= '0;
    end else begin
      ack <= req && (ack || grant);
      if (grant) data <= rd_data;
    end
  end
endmodule

module route_table_ctrl #(
  parameter int CHANNELS         = 5,
  parameter int CHANNEL_BITS     = 8,
  parameter int DESTINATION_BITS = 7
) (
  input  logic                                 clk,
  input  logic                                 reset,
  output logic [DESTINATION_BITS-1:0]          table_addr,
  input  logic [CHANNEL_BITS-1:0]              table_data,
  output logic                                 ready,
  input  logic [CHANNELS-1:0]                  lk_req,
  input  logic [CHANNELS*DESTINATION_BITS-1:0] lk_addr,
  output logic [CHANNELS-1:0]                  lk_ack,
  output logic [CHANNELS*CHANNEL_BITS-1:0]     lk_data,
  input  logic                                 cfg_req,
  input  logic [DESTINATION_BITS-1:0]          cfg_addr,
  input  logic [CHANNEL_BITS-1:0]              cfg_data,
  output logic                                 cfg_ack
);
  localparam int DESTINATIONS = 2**DESTINATION_BITS;
  localparam int PTR_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {INIT, SERVE} state_t;

  state_t                                 state_q, state_d;
  logic [CHANNEL_BITS-1:0]                tbl [DESTINATIONS];
  logic [PTR_W-1:0]                       ptr_q, win, idx;
  logic                                   found, cfg_win;
  logic [CHANNELS-1:0]                    elig, gnt;
  logic [CHANNELS-1:0][CHANNEL_BITS-1:0]  rd_data;

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && (&table_addr)) state_d = SERVE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      table_addr <= '0;
      ready      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) begin
        table_addr <= table_addr + 1'b1;
        if (&table_addr) ready <= 1'b1;
      end
    end
  end

  // Scan pointer+1 .. pointer+CHANNELS, first eligible channel wins
  always_comb begin
    elig  = lk_req & ~lk_ack;
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % CHANNELS);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign cfg_win = cfg_req && !cfg_ack && (state_q == SERVE);

  always_comb begin
    gnt = '0;
    if (state_q == SERVE && !cfg_win && found) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= PTR_W'(CHANNELS - 1);
      cfg_ack <= 1'b0;
    end else begin
      if (|gnt) ptr_q <= win;
      cfg_ack <= cfg_req && (cfg_ack || state_q == SERVE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < DESTINATIONS; a++) tbl[a] <= '0;
    end else if (state_q == INIT) begin
      tbl[table_addr] <= table_data;
    end else if (cfg_win) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign rd_data[i] = tbl[lk_addr[i*DESTINATION_BITS +: DESTINATION_BITS]];

    route_table_lane #(.CHANNEL_BITS(CHANNEL_BITS)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .req     (lk_req[i]),
      .grant   (gnt[i]),
      .rd_data (rd_data[i]),
      .ack     (lk_ack[i]),
      .data    (lk_data[i*CHANNEL_BITS +: CHANNEL_BITS])
    );
  end
endmodule

// File: tb/tb_route_table_ctrl.sv
// Directed plus randomized bench for route_table_ctrl; a plain table array
// stands in for the routing table when checking lookups and handshake rules.

module tb_route_table_ctrl;
  localparam int CH = 5;
  localparam int CB = 8;
  localparam int DB = 3;
  localparam int ND = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [DB-1:0]     table_addr;
  logic [CB-1:0]     table_data;
  logic              ready;
  logic [CH-1:0]     lk_req;
  logic [CH*DB-1:0]  lk_addr;
  logic [CH-1:0]     lk_ack;
  logic [CH*CB-1:0]  lk_data;
  logic              cfg_req;
  logic [DB-1:0]     cfg_addr;
  logic [CB-1:0]     cfg_data;
  logic              cfg_ack;

  logic [CB-1:0]     tbl_m [ND];
  int checks = 0;
  int errors = 0;

  route_table_ctrl #(.CHANNELS(CH), .CHANNEL_BITS(CB), .DESTINATION_BITS(DB)) dut (
    .clk(clk), .reset(reset), .table_addr(table_addr), .table_data(table_data),
    .ready(ready), .lk_req(lk_req), .lk_addr(lk_addr), .lk_ack(lk_ack),
    .lk_data(lk_data), .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ack(cfg_ack)
  );

  assign table_data = CB'(table_addr) + 8'h10;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CB-1:0] dat(input int i);
    return lk_data[i*CB +: CB];
  endfunction

  function automatic logic [DB-1:0] adr(input int i);
    return lk_addr[i*DB +: DB];
  endfunction

  task automatic set_req(input int i, input int a);
    lk_addr[i*DB +: DB] = DB'(a);
    lk_req[i] = 1'b1;
  endtask

  task automatic do_preload();
    for (int n = 1; n <= ND; n++) begin
      @(negedge clk);
      check("preload_ready", ready, (n == ND) ? 1 : 0);
      check("preload_addr", table_addr, (n == ND) ? 0 : n);
      check("preload_no_ack", {cfg_ack, lk_ack}, 0);
    end
  endtask

  task automatic run_random(input int cycles, input bit use_cfg, input int bound);
    logic [CH-1:0] ack_prev;
    logic          cfg_prev;
    int            wait_c [CH];
    logic [CB-1:0] held   [CH];
    int            maxw;
    int            rises;
    bit            drain;
    ack_prev = lk_ack;
    cfg_prev = cfg_ack;
    maxw = 0;
    for (int i = 0; i < CH; i++) begin wait_c[i] = 0; held[i] = dat(i); end
    for (int cyc = 0; cyc < cycles + 3*bound; cyc++) begin
      drain = (cyc >= cycles);
      @(negedge clk);
      rises = 0;
      if (cfg_req && !cfg_prev) begin
        check("rand_cfg_prio", cfg_ack, 1);
        tbl_m[cfg_addr] = cfg_data;
        rises++;
      end else if (!cfg_req && cfg_prev) begin
        check("rand_cfg_clear", cfg_ack, 0);
      end
      for (int i = 0; i < CH; i++) begin
        if (lk_req[i] && !ack_prev[i]) begin
          if (lk_ack[i]) begin
            rises++;
            check("rand_data", dat(i), tbl_m[adr(i)]);
            held[i] = dat(i);
            if (wait_c[i] + 1 > maxw) maxw = wait_c[i] + 1;
            wait_c[i] = 0;
          end else begin
            wait_c[i]++;
            if (wait_c[i] > maxw) maxw = wait_c[i];
          end
        end else if (lk_req[i] && ack_prev[i]) begin
          check("rand_hold", {lk_ack[i], dat(i)}, {1'b1, held[i]});
        end else if (!lk_req[i] && ack_prev[i]) begin
          check("rand_ack_clear", lk_ack[i], 0);
        end
      end
      check("rand_one_access", (rises <= 1) ? 1 : 0, 1);
      ack_prev = lk_ack;
      cfg_prev = cfg_ack;
      for (int i = 0; i < CH; i++) begin
        if (lk_req[i] && lk_ack[i]) begin
          if (drain || $urandom_range(2) != 0) lk_req[i] = 1'b0;
        end else if (!lk_req[i] && !lk_ack[i] && !drain && $urandom_range(1) == 1) begin
          set_req(i, int'($urandom_range(ND-1)));
        end
      end
      if (use_cfg) begin
        if (cfg_req && cfg_ack) cfg_req = 1'b0;
        else if (!cfg_req && !cfg_ack && !drain && $urandom_range(3) == 0) begin
          cfg_addr = DB'($urandom_range(ND-1));
          cfg_data = CB'($urandom_range(255));
          cfg_req  = 1'b1;
        end
      end
    end
    check("rand_max_wait", (maxw <= bound) ? 1 : 0, 1);
    check("rand_idle", {cfg_req, cfg_ack, lk_req, lk_ack}, 0);
  endtask

  initial begin
    reset = 1'b1; lk_req = '0; lk_addr = '0;
    cfg_req = 1'b0; cfg_addr = '0; cfg_data = '0;
    @(negedge clk); @(negedge clk);
    check("reset_state", {table_addr, ready, lk_ack, cfg_ack}, 0);
    check("reset_data", lk_data, 0);

    // Preload with a lookup already pending from channel 0
    set_req(0, 3);
    reset = 1'b0;
    do_preload();
    @(negedge clk);
    check("first_ack", lk_ack, 5'b00001);
    check("first_data", dat(0), 8'h13);
    check("addr_held", table_addr, 0);
    lk_req[0] = 1'b0;
    @(negedge clk);
    check("first_clear", lk_ack, 0);

    set_req(2, 5);
    @(negedge clk);
    check("single_ack", lk_ack, 5'b00100);
    check("single_data", dat(2), 8'h15);
    lk_req[2] = 1'b0;
    @(negedge clk);
    check("single_clear", lk_ack, 0);
    check("single_keep", dat(2), 8'h15);

    // Park the pointer on channel 4 so contention starts at channel 0
    set_req(4, 1);
    @(negedge clk);
    check("park_ack", lk_ack, 5'b10000);
    check("park_data", dat(4), 8'h11);
    lk_req[4] = 1'b0;
    @(negedge clk);

    for (int i = 0; i < CH; i++) set_req(i, i + 2);
    for (int k = 1; k <= CH; k++) begin
      @(negedge clk);
      check("contend_ack", lk_ack, (1 << k) - 1);
      check("contend_data", dat(k-1), 8'h10 + k + 1);
    end
    lk_req = '0;
    @(negedge clk);
    check("contend_clear", lk_ack, 0);

    set_req(3, 7);
    @(negedge clk);
    check("rr_prep", lk_ack, 5'b01000);
    lk_req[3] = 1'b0;
    @(negedge clk);
    set_req(1, 0);
    set_req(4, 4);
    @(negedge clk);
    check("rr_first", lk_ack, 5'b10000);
    check("rr_first_data", dat(4), 8'h14);
    @(negedge clk);
    check("rr_second", lk_ack, 5'b10010);
    check("rr_second_data", dat(1), 8'h10);
    lk_req = '0;
    @(negedge clk);

    cfg_req = 1'b1; cfg_addr = 3'd5; cfg_data = 8'hAA;
    set_req(0, 5);
    @(negedge clk);
    check("wr_prio", {cfg_ack, lk_ack}, 6'b100000);
    @(negedge clk);
    check("raw_ack", {cfg_ack, lk_ack}, 6'b100001);
    check("raw_data", dat(0), 8'hAA);
    cfg_req = 1'b0; lk_req = '0;
    @(negedge clk);
    check("wr_clear", {cfg_ack, lk_ack}, 0);

    // Asynchronous reset while handshakes are open
    cfg_req = 1'b1; cfg_addr = 3'd2; cfg_data = 8'h55;
    set_req(1, 6);
    @(negedge clk);
    check("mid_cfg_ack", {cfg_ack, lk_ack}, 6'b100000);
    @(negedge clk);
    check("mid_lk_ack", {cfg_ack, lk_ack}, 6'b100010);
    #2 reset = 1'b1;
    #1;
    check("async_reset", {table_addr, ready, lk_ack, cfg_ack}, 0);
    check("async_reset_data", lk_data, 0);
    cfg_req = 1'b0; lk_req = '0;
    @(negedge clk);
    reset = 1'b0;
    do_preload();
    set_req(2, 5);
    @(negedge clk);
    check("reload_data", {lk_ack, dat(2)}, {5'b00100, 8'h15});
    lk_req = '0;
    @(negedge clk);

    for (int a = 0; a < ND; a++) tbl_m[a] = CB'(a) + 8'h10;
    run_random(400, 1'b0, CH);
    run_random(400, 1'b1, 2*CH + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
